// File: rtl/shift_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_unit_if
//  Description : Request/response bundle for the multi-cycle shift unit.
//                The requester side uses the master modport and the shifter
//                uses the slave modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface shift_unit_if #(
    parameter int WIDTH = 64
);
    localparam int NSTG = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             word;
    logic [WIDTH-1:0] operand;
    logic [NSTG-1:0]  shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output in_valid, op, word, operand, shamt, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, word, operand, shamt, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface
`default_nettype wire

// File: rtl/shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : shift_unit
//  Description : Multi-cycle log2 barrel shifter (SLL/SRL/SRA/IMM2, RV64 word
//                forms). SPC barrel stages are evaluated per BUSY cycle, LSB
//                stage first; one request in flight at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_unit #(
    parameter int WIDTH = 64,
    parameter int SPC   = 2
) (
    input  wire logic    clk,
    input  wire logic    reset,
    shift_unit_if.slave  bus
);
    localparam int NSTG = $clog2(WIDTH);
    localparam int N    = (NSTG + SPC - 1) / SPC;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] KIND_SLL = 2'b00;
    localparam logic [1:0] KIND_SRL = 2'b01;
    localparam logic [1:0] KIND_SRA = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  work;
    logic [NSTG-1:0]   sh_reg;
    logic [1:0]        kind_reg;
    logic [WIDTH-1:0]  result_reg;

    logic              accept;
    logic [1:0]        eff_kind;
    logic [NSTG-1:0]   eff_shamt;
    logic [WIDTH-1:0]  pre_val;
    logic [NSTG-1:0]   pre_sh;
    logic [WIDTH-1:0]  stage_val;
    logic [WIDTH-1:0]  post_val;

    assign accept        = bus.in_valid && (state == IDLE);
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = result_reg;

    // IMM2 is executed as a left shift by one regardless of shamt
    assign eff_kind  = (bus.op == 2'b11) ? KIND_SLL : bus.op;
    assign eff_shamt = (bus.op == 2'b11) ? NSTG'(1) : bus.shamt;

    generate
        if (WIDTH == 64) begin : g_word64
            logic word_reg;

            // Word forms: 5-bit amount, upper half prepared so right shifts
            // pull in the correct bits from the 32-bit value
            always_comb begin
                pre_val = bus.operand;
                pre_sh  = eff_shamt;
                if (bus.word) begin
                    pre_sh[5] = 1'b0;
                    if (eff_kind == KIND_SRA) begin
                        pre_val[63:32] = {32{bus.operand[31]}};
                    end else if (eff_kind == KIND_SRL) begin
                        pre_val[63:32] = '0;
                    end
                end
            end

            // Word flag is latched with the rest of the request
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    word_reg <= 1'b0;
                end else if (accept) begin
                    word_reg <= bus.word;
                end
            end

            assign post_val = word_reg ? {{32{stage_val[31]}}, stage_val[31:0]}
                                       : stage_val;
        end else begin : g_noword
            assign pre_val  = bus.operand;
            assign pre_sh   = eff_shamt;
            assign post_val = stage_val;
        end
    endgenerate

    // Barrel stages belonging to the current BUSY cycle, LSB stage first
    always_comb begin
        stage_val = work;
        for (int i = 0; i < NSTG; i++) begin
            if ((cnt == CW'(i / SPC)) && sh_reg[i]) begin
                case (kind_reg)
                    KIND_SRL: stage_val = stage_val >> (2 ** i);
                    KIND_SRA: stage_val = $unsigned($signed(stage_val) >>> (2 ** i));
                    default:  stage_val = stage_val << (2 ** i);
                endcase
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)          state_nxt = BUSY;
            BUSY:    if (cnt == LAST)     state_nxt = DONE;
            DONE:    if (bus.out_ready)   state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Working registers: capture on accept, step through stages while BUSY,
    // publish the result only on the last BUSY edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work       <= '0;
            sh_reg     <= '0;
            kind_reg   <= KIND_SLL;
            cnt        <= '0;
            result_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        work     <= pre_val;
                        sh_reg   <= pre_sh;
                        kind_reg <= eff_kind;
                        cnt      <= '0;
                    end
                end
                BUSY: begin
                    work <= stage_val;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        result_reg <= post_val;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_unit
//  Description : Self-checking bench for shift_unit; three instances with
//                SPC = 2, 1 and 6 share stimulus, expected results go through
//                a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]  s_op;
    logic        s_word;
    logic [63:0] s_operand;
    logic [5:0]  s_shamt;
    logic [2:0]  iv;
    logic [2:0]  ordy;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    shift_unit_if #(.WIDTH(64)) b2 ();
    shift_unit_if #(.WIDTH(64)) b1 ();
    shift_unit_if #(.WIDTH(64)) b6 ();

    shift_unit #(.WIDTH(64), .SPC(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
    shift_unit #(.WIDTH(64), .SPC(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    shift_unit #(.WIDTH(64), .SPC(6)) dut6 (.clk(clk), .reset(reset), .bus(b6));

    assign b2.op = s_op;  assign b2.word = s_word;  assign b2.operand = s_operand;  assign b2.shamt = s_shamt;
    assign b1.op = s_op;  assign b1.word = s_word;  assign b1.operand = s_operand;  assign b1.shamt = s_shamt;
    assign b6.op = s_op;  assign b6.word = s_word;  assign b6.operand = s_operand;  assign b6.shamt = s_shamt;
    assign b2.in_valid = iv[0];  assign b2.out_ready = ordy[0];
    assign b1.in_valid = iv[1];  assign b1.out_ready = ordy[1];
    assign b6.in_valid = iv[2];  assign b6.out_ready = ordy[2];

    function automatic logic g_in_ready(int sel);
        case (sel)
            0:       return b2.in_ready;
            1:       return b1.in_ready;
            default: return b6.in_ready;
        endcase
    endfunction

    function automatic logic g_out_valid(int sel);
        case (sel)
            0:       return b2.out_valid;
            1:       return b1.out_valid;
            default: return b6.out_valid;
        endcase
    endfunction

    function automatic logic g_busy(int sel);
        case (sel)
            0:       return b2.busy;
            1:       return b1.busy;
            default: return b6.busy;
        endcase
    endfunction

    function automatic logic [63:0] g_result(int sel);
        case (sel)
            0:       return b2.result;
            1:       return b1.result;
            default: return b6.result;
        endcase
    endfunction

    function automatic int lat_of(int sel);
        case (sel)
            0:       return 3;
            1:       return 6;
            default: return 1;
        endcase
    endfunction

    // RISC-V reference semantics for the shift ops
    function automatic logic [63:0] model(logic [1:0] op, logic w, logic [63:0] a, logic [5:0] s);
        logic [1:0]  k;
        logic [5:0]  sh;
        logic [31:0] lo;
        logic [63:0] r;
        k  = (op == 2'b11) ? 2'b00 : op;
        sh = (op == 2'b11) ? 6'd1 : s;
        if (w) begin
            lo = a[31:0];
            case (k)
                2'b00:   lo = lo << sh[4:0];
                2'b01:   lo = lo >> sh[4:0];
                default: lo = $unsigned($signed(lo) >>> sh[4:0]);
            endcase
            r = {{32{lo[31]}}, lo};
        end else begin
            case (k)
                2'b00:   r = a << sh;
                2'b01:   r = a >> sh;
                default: r = $unsigned($signed(a) >>> sh);
            endcase
        end
        return r;
    endfunction

    // Issue one request, push its expectation, wait for out_valid (bounded).
    // Inputs are scrambled right after acceptance.
    task automatic run_op(input int sel, input logic [1:0] op, input logic w,
                          input logic [63:0] a, input logic [5:0] s, input logic [63:0] expv,
                          output int lat, output logic [63:0] got, output bit ok);
        int t;
        exp_q.push_back(expv);
        s_op = op; s_word = w; s_operand = a; s_shamt = s;
        iv[sel] = 1'b1;
        t = 0;
        while (g_in_ready(sel) !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 50) begin
            iv[sel] = 1'b0; ok = 1'b0; lat = -1; got = '0;
            return;
        end
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        s_op = ~op; s_word = ~w; s_operand = ~a; s_shamt = ~s;
        lat = 0;
        while (g_out_valid(sel) !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        ok  = (g_out_valid(sel) === 1'b1);
        got = g_result(sel);
    endtask

    task automatic drain(input int sel);
        ordy[sel] = 1'b1;
        @(posedge clk); #1;
        ordy[sel] = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int sel = 0; sel < 3; sel++) begin
            checks++; if (g_in_ready(sel) !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got %b want 1", sel, g_in_ready(sel)); end
            checks++; if (g_out_valid(sel) !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got %b want 0", sel, g_out_valid(sel)); end
            checks++; if (g_busy(sel) !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b want 0", sel, g_busy(sel)); end
            checks++; if (g_result(sel) !== 64'h0) begin errors++; $display("FAIL reset_result[%0d] got %h want 0", sel, g_result(sel)); end
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sll_max;
        int lat; logic [63:0] got, e; bit ok;
        run_op(0, 2'b00, 1'b0, 64'h1, 6'd63, 64'h8000_0000_0000_0000, lat, got, ok);
        e = exp_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL sll_max_done got no out_valid want out_valid"); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL sll_max_latency got %0d want 3", lat); end
        checks++; if (got !== e) begin errors++; $display("FAIL sll_max_result got %h want %h", got, e); end
        checks++; if (g_busy(0) !== 1'b1) begin errors++; $display("FAIL done_busy got %b want 1", g_busy(0)); end
        drain(0);
    endtask

    task automatic test_shifts;
        logic [1:0]  ops [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [63:0] opa [4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                                 64'hFFFF_FFFF_FFFF_FFF8, 64'hF0};
        logic [5:0]  shs [4] = '{6'd4, 6'd4, 6'h3F, 6'd0};
        logic [63:0] exv [4] = '{64'hF800_0000_0000_0000, 64'h0800_0000_0000_0000,
                                 64'hFFFF_FFFF_FFFF_FFF0, 64'hF0};
        int lat; logic [63:0] got, e; bit ok;
        for (int i = 0; i < 4; i++) begin
            run_op(0, ops[i], 1'b0, opa[i], shs[i], exv[i], lat, got, ok);
            e = exp_q.pop_front();
            checks++; if (!ok || lat !== 3) begin errors++; $display("FAIL shift[%0d]_latency got %0d want 3", i, lat); end
            checks++; if (got !== e) begin errors++; $display("FAIL shift[%0d]_result got %h want %h", i, got, e); end
            drain(0);
        end
    endtask

    task automatic test_word;
        logic [1:0]  ops [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
        logic [63:0] opa [4] = '{64'h0000_0000_8000_0000, 64'h1, 64'hFFFF_FFFF_8000_0000,
                                 64'h1234_5678_4000_0001};
        logic [5:0]  shs [4] = '{6'h21, 6'd31, 6'd4, 6'd9};
        logic [63:0] exv [4] = '{64'hFFFF_FFFF_C000_0000, 64'hFFFF_FFFF_8000_0000,
                                 64'h0000_0000_0800_0000, 64'hFFFF_FFFF_8000_0002};
        int lat; logic [63:0] got, e; bit ok;
        for (int i = 0; i < 4; i++) begin
            run_op(0, ops[i], 1'b1, opa[i], shs[i], exv[i], lat, got, ok);
            e = exp_q.pop_front();
            checks++; if (!ok) begin errors++; $display("FAIL word[%0d]_done got no out_valid want out_valid", i); end
            checks++; if (got !== e) begin errors++; $display("FAIL word[%0d]_result got %h want %h", i, got, e); end
            drain(0);
        end
    endtask

    task automatic test_backpressure;
        int lat; logic [63:0] got, e; bit ok;
        run_op(0, 2'b01, 1'b0, 64'hA5A5_0000_1234_5678, 6'd8, 64'h00A5_A500_0012_3456, lat, got, ok);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL bp_result got %h want %h", got, e); end
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                s_op = 2'b00; s_word = 1'b0; s_operand = 64'h3; s_shamt = 6'd2;
                iv[0] = 1'b1;
            end
            @(posedge clk); #1;
            iv[0] = 1'b0;
            checks++; if (g_out_valid(0) !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got %b want 1", c, g_out_valid(0)); end
            checks++; if (g_in_ready(0) !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", c, g_in_ready(0)); end
            checks++; if (g_result(0) !== e) begin errors++; $display("FAIL bp_hold[%0d] got %h want %h", c, g_result(0), e); end
        end
        drain(0);
        checks++; if (g_in_ready(0) !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", g_in_ready(0)); end
        checks++; if (g_out_valid(0) !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", g_out_valid(0)); end
        checks++; if (g_result(0) !== e) begin errors++; $display("FAIL idle_hold got %h want %h", g_result(0), e); end
    endtask

    task automatic test_reset_mid_busy;
        logic [63:0] prev; int lat; logic [63:0] got, e; bit ok; int t;
        prev = 64'h00A5_A500_0012_3456;
        s_op = 2'b00; s_word = 1'b0; s_operand = 64'h1; s_shamt = 6'd5;
        iv[0] = 1'b1;
        t = 0;
        while (g_in_ready(0) !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        iv[0] = 1'b0;
        checks++; if (g_busy(0) !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", g_busy(0)); end
        checks++; if (g_result(0) !== prev) begin errors++; $display("FAIL busy_hold got %h want %h", g_result(0), prev); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++; if (g_out_valid(0) !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b want 0", g_out_valid(0)); end
        checks++; if (g_result(0) !== 64'h0) begin errors++; $display("FAIL abort_result got %h want 0", g_result(0)); end
        checks++; if (g_in_ready(0) !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b want 1", g_in_ready(0)); end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++; if (g_out_valid(0) !== 1'b0) begin errors++; $display("FAIL abort_no_output[%0d] got %b want 0", c, g_out_valid(0)); end
        end
        run_op(0, 2'b10, 1'b0, 64'hF0, 6'd4, 64'hF, lat, got, ok);
        e = exp_q.pop_front();
        checks++; if (!ok || lat !== 3) begin errors++; $display("FAIL post_reset_latency got %0d want 3", lat); end
        checks++; if (got !== e) begin errors++; $display("FAIL post_reset_result got %h want %h", got, e); end
        drain(0);
    endtask

    task automatic test_sweep;
        int lat; logic [63:0] got, e; bit ok;
        for (int sel = 1; sel < 3; sel++) begin
            run_op(sel, 2'b00, 1'b0, 64'h1, 6'd63, 64'h8000_0000_0000_0000, lat, got, ok);
            e = exp_q.pop_front();
            checks++; if (!ok || lat !== lat_of(sel)) begin errors++; $display("FAIL sweep[%0d]_latency got %0d want %0d", sel, lat, lat_of(sel)); end
            checks++; if (got !== e) begin errors++; $display("FAIL sweep[%0d]_result got %h want %h", sel, got, e); end
            drain(sel);
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic [63:0] got, e, a; bit ok; logic [1:0] op; logic w; logic [5:0] s;
        for (int k = 0; k < 18; k++) begin
            op = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            s  = 6'($urandom_range(0, 63));
            run_op(k % 3, op, w, a, s, model(op, w, a, s), lat, got, ok);
            e = exp_q.pop_front();
            checks++; if (!ok || lat !== lat_of(k % 3)) begin errors++; $display("FAIL b2b[%0d]_latency got %0d want %0d", k, lat, lat_of(k % 3)); end
            checks++; if (got !== e) begin errors++; $display("FAIL b2b[%0d]_result op=%0d w=%0d a=%h s=%0d got %h want %h", k, op, w, a, s, got, e); end
            drain(k % 3);
        end
    endtask

    initial begin
        iv = '0; ordy = '0;
        s_op = '0; s_word = 1'b0; s_operand = '0; s_shamt = '0;
        test_reset();
        test_sll_max();
        test_shifts();
        test_word();
        test_backpressure();
        test_reset_mid_busy();
        test_sweep();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
